hostbus_regctrl: RTL and testbench

- Host-side register access controller for the motor control block.
- Converts an asynchronous 8-bit parallel host bus (chip select, read and write strobes) into single-cycle, clock-synchronous register load strobes (config, control, watchdog divisor).
- Muxes register readback onto the host data-out bus.
- Generates the control-register-read pulse that resets the watchdog timer.

---
 rtl/hostbus_regctrl.sv | 185 ++++++++++++++++++
 tb/tb_hostbus_regctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hostbus_regctrl.sv
// rtl/hostbus_regctrl.sv - host bus to synchronous register strobe controller
//
// Purpose: turns an asynchronous 8-bit host bus (hcs_n/hwr_n/hrd_n) into
// single-cycle register load strobes, muxes register readback onto hdataout
// and pulses ctrlrdce on every read of the control register.
//
// Ports:
//   clk, resetn                 system clock, synchronous active-low reset
//   hcs_n, hwr_n, hrd_n         async host strobes (active-low)
//   haddr, hdatain              host address / write data (sampled on capture)
//   hdataout                    registered host read data
//   configrd, controlrddata,
//   wdogdivrd                   register readback sources
//   wrtdata                     registered write data to the register file
//   cfgld, ctrlld, wdogdivld    one-cycle load strobes for addresses 0/1/2
//   ctrlrdce                    one-cycle pulse per read of address 1
//   buserr                      one-cycle pulse on protocol error
module hostbus_regctrl #(
  parameter int         SYNCSTAGES = 2,
  parameter logic [7:0] IDVALUE    = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       hcs_n,
  input  logic       hwr_n,
  input  logic       hrd_n,
  input  logic [1:0] haddr,
  input  logic [7:0] hdatain,
  output logic [7:0] hdataout,
  input  logic [7:0] configrd,
  input  logic [7:0] controlrddata,
  input  logic [7:0] wdogdivrd,
  output logic [7:0] wrtdata,
  output logic       cfgld,
  output logic       ctrlld,
  output logic       wdogdivld,
  output logic       ctrlrdce,
  output logic       buserr
);

  typedef enum logic [2:0] {
    ST_ARM, ST_IDLE, ST_WRACT, ST_RDACT, ST_ERRWAIT
  } state_e;

  state_e state_q, state_d;

  logic [SYNCSTAGES-1:0] cs_sync_q, wr_sync_q, rd_sync_q;
  logic                  armed_q;
  logic [1:0]            addr_q, addr_d;
  logic [7:0]            hdataout_q, hdataout_d;
  logic [7:0]            wrtdata_q, wrtdata_d;
  logic                  cfgld_q, cfgld_d;
  logic                  ctrlld_q, ctrlld_d;
  logic                  wdogdivld_q, wdogdivld_d;
  logic                  ctrlrdce_q, ctrlrdce_d;
  logic                  buserr_q, buserr_d;

  logic cs_act, wr_act, rd_act, quiet_all;

  // Synchronized strobes, true when the host strobe is asserted (low).
  assign cs_act = ~cs_sync_q[SYNCSTAGES-1];
  assign wr_act = ~wr_sync_q[SYNCSTAGES-1];
  assign rd_act = ~rd_sync_q[SYNCSTAGES-1];

  // ARM looks at every synchronizer stage, not just the last one: the chain
  // comes out of reset full of ones, so only a fully refilled chain proves
  // the host really released wr/rd after reset.
  assign quiet_all = (&wr_sync_q) && (&rd_sync_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_ARM;
      cs_sync_q   <= '1;
      wr_sync_q   <= '1;
      rd_sync_q   <= '1;
      armed_q     <= 1'b0;
      addr_q      <= 2'd0;
      hdataout_q  <= 8'd0;
      wrtdata_q   <= 8'd0;
      cfgld_q     <= 1'b0;
      ctrlld_q    <= 1'b0;
      wdogdivld_q <= 1'b0;
      ctrlrdce_q  <= 1'b0;
      buserr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= {cs_sync_q[SYNCSTAGES-2:0], hcs_n};
      wr_sync_q   <= {wr_sync_q[SYNCSTAGES-2:0], hwr_n};
      rd_sync_q   <= {rd_sync_q[SYNCSTAGES-2:0], hrd_n};
      // First post-reset cycle is skipped so the chain holds a real sample.
      armed_q     <= 1'b1;
      addr_q      <= addr_d;
      hdataout_q  <= hdataout_d;
      wrtdata_q   <= wrtdata_d;
      cfgld_q     <= cfgld_d;
      ctrlld_q    <= ctrlld_d;
      wdogdivld_q <= wdogdivld_d;
      ctrlrdce_q  <= ctrlrdce_d;
      buserr_q    <= buserr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hdataout_d  = hdataout_q;
    wrtdata_d   = wrtdata_q;
    cfgld_d     = 1'b0;
    ctrlld_d    = 1'b0;
    wdogdivld_d = 1'b0;
    ctrlrdce_d  = 1'b0;
    buserr_d    = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (armed_q && quiet_all) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (cs_act) begin
          if (wr_act && rd_act) begin
            buserr_d = 1'b1;
            state_d  = ST_ERRWAIT;
          end else if (wr_act) begin
            addr_d    = haddr;
            wrtdata_d = hdatain;
            state_d   = ST_WRACT;
          end else if (rd_act) begin
            addr_d = haddr;
            case (haddr)
              2'd0:    hdataout_d = configrd;
              2'd1:    hdataout_d = controlrddata;
              2'd2:    hdataout_d = wdogdivrd;
              default: hdataout_d = IDVALUE;
            endcase
            ctrlrdce_d = (haddr == 2'd1);
            state_d    = ST_RDACT;
          end
        end
      end

      ST_WRACT: begin
        // Losing chip select wins over a simultaneous wr release.
        if (!cs_act) begin
          state_d = ST_ARM;
        end else if (rd_act) begin
          buserr_d = 1'b1;
          state_d  = ST_ERRWAIT;
        end else if (!wr_act) begin
          case (addr_q)
            2'd0:    cfgld_d     = 1'b1;
            2'd1:    ctrlld_d    = 1'b1;
            2'd2:    wdogdivld_d = 1'b1;
            default: ;
          endcase
          state_d = ST_IDLE;
        end
      end

      ST_RDACT: begin
        if (wr_act) begin
          buserr_d = 1'b1;
          state_d  = ST_ERRWAIT;
        end else if (!rd_act) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERRWAIT: begin
        if (!wr_act && !rd_act) state_d = ST_IDLE;
      end

      default: state_d = ST_ARM;
    endcase
  end

  assign hdataout  = hdataout_q;
  assign wrtdata   = wrtdata_q;
  assign cfgld     = cfgld_q;
  assign ctrlld    = ctrlld_q;
  assign wdogdivld = wdogdivld_q;
  assign ctrlrdce  = ctrlrdce_q;
  assign buserr    = buserr_q;

endmodule

// File: tb/tb_hostbus_regctrl.sv
// tb/tb_hostbus_regctrl.sv - self-checking bench for hostbus_regctrl
module tb_hostbus_regctrl;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       resetn, hcs_n, hwr_n, hrd_n;
  logic [1:0] haddr;
  logic [7:0] hdatain, configrd, controlrddata, wdogdivrd;
  logic [7:0] hdataout, wrtdata;
  logic       cfgld, ctrlld, wdogdivld, ctrlrdce, buserr;

  hostbus_regctrl #(.SYNCSTAGES(SYNC), .IDVALUE(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .hcs_n(hcs_n), .hwr_n(hwr_n), .hrd_n(hrd_n),
    .haddr(haddr), .hdatain(hdatain), .hdataout(hdataout),
    .configrd(configrd), .controlrddata(controlrddata), .wdogdivrd(wdogdivrd),
    .wrtdata(wrtdata), .cfgld(cfgld), .ctrlld(ctrlld), .wdogdivld(wdogdivld),
    .ctrlrdce(ctrlrdce), .buserr(buserr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int c_cfg = 0, c_ctrl = 0, c_wdog = 0, c_rdce = 0, c_err = 0, c_multi = 0;

  always @(negedge clk) begin
    if (cfgld)     c_cfg  = c_cfg + 1;
    if (ctrlld)    c_ctrl = c_ctrl + 1;
    if (wdogdivld) c_wdog = c_wdog + 1;
    if (ctrlrdce)  c_rdce = c_rdce + 1;
    if (buserr)    c_err  = c_err + 1;
    if (int'(cfgld) + int'(ctrlld) + int'(wdogdivld) > 1) c_multi = c_multi + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    c_cfg = 0; c_ctrl = 0; c_wdog = 0; c_rdce = 0; c_err = 0;
  endtask

  function automatic int out_word();
    return int'({hdataout, wrtdata, cfgld, ctrlld, wdogdivld, ctrlrdce, buserr});
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, output int lat);
    lat = 0;
    @(negedge clk); hcs_n = 1'b0; haddr = a; hdatain = d;
    @(negedge clk); hwr_n = 1'b0;
    repeat (8) @(negedge clk);
    hwr_n = 1'b1;
    for (int k = 1; k <= SYNC + 3; k++) begin
      @(negedge clk);
      if ((cfgld | ctrlld | wdogdivld) && lat == 0) lat = k;
    end
    hcs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, output int lat, output logic [7:0] dout_at);
    lat = 0;
    dout_at = 8'h00;
    @(negedge clk); hcs_n = 1'b0; haddr = a;
    @(negedge clk); hrd_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ctrlrdce && lat == 0) lat = k;
      if (k == SYNC + 1) dout_at = hdataout;
    end
    hrd_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    hcs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  typedef struct {
    bit         is_wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] ctrlrd;
    logic [7:0] exp_dout;
    logic [7:0] exp_wrt;
    logic [3:0] exp_cnt;   // {cfgld, ctrlld, wdogdivld, ctrlrdce} pulse counts
  } vec_t;

  vec_t vecs[9];

  initial begin
    int         lat;
    logic [7:0] dout_at;

    resetn = 1'b0; hcs_n = 1'b1; hwr_n = 1'b1; hrd_n = 1'b1;
    haddr = 2'd0; hdatain = 8'h00;
    configrd = 8'h3C; controlrddata = 8'h00; wdogdivrd = 8'h40;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_word(), 0);
    resetn = 1'b1;
    repeat (SYNC + 4) @(negedge clk);

    vecs[0] = '{1'b1, 2'd0, 8'h2C, 8'h00, 8'h00, 8'h2C, 4'b1000};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 8'h88, 8'h88, 8'h2C, 4'b0001};
    vecs[2] = '{1'b0, 2'd1, 8'h00, 8'h81, 8'h81, 8'h2C, 4'b0001};
    vecs[3] = '{1'b0, 2'd2, 8'h00, 8'h00, 8'h40, 8'h2C, 4'b0000};
    vecs[4] = '{1'b0, 2'd3, 8'h00, 8'h00, 8'hA5, 8'h2C, 4'b0000};
    vecs[5] = '{1'b1, 2'd3, 8'hFF, 8'h00, 8'hA5, 8'hFF, 4'b0000};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h3C, 8'hFF, 4'b0000};
    vecs[7] = '{1'b1, 2'd1, 8'h77, 8'h00, 8'h3C, 8'h77, 4'b0100};
    vecs[8] = '{1'b1, 2'd2, 8'h10, 8'h00, 8'h3C, 8'h10, 4'b0010};

    for (int i = 0; i < 9; i++) begin
      clear_counts();
      controlrddata = vecs[i].ctrlrd;
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, lat);
        check($sformatf("v%0d_wr_latency", i), lat,
              (vecs[i].exp_cnt[3:1] != 3'b000) ? SYNC + 1 : 0);
      end else begin
        do_read(vecs[i].addr, lat, dout_at);
        check($sformatf("v%0d_rdce_latency", i), lat, vecs[i].exp_cnt[0] ? SYNC + 1 : 0);
        check($sformatf("v%0d_dout_at_latency", i), int'(dout_at), int'(vecs[i].exp_dout));
      end
      check($sformatf("v%0d_hdataout", i), int'(hdataout), int'(vecs[i].exp_dout));
      check($sformatf("v%0d_wrtdata", i), int'(wrtdata), int'(vecs[i].exp_wrt));
      check($sformatf("v%0d_cfgld", i), c_cfg, int'(vecs[i].exp_cnt[3]));
      check($sformatf("v%0d_ctrlld", i), c_ctrl, int'(vecs[i].exp_cnt[2]));
      check($sformatf("v%0d_wdogdivld", i), c_wdog, int'(vecs[i].exp_cnt[1]));
      check($sformatf("v%0d_ctrlrdce", i), c_rdce, int'(vecs[i].exp_cnt[0]));
      check($sformatf("v%0d_buserr", i), c_err, 0);
    end

    // wr and rd asserted together: one buserr, nothing else, readback kept.
    clear_counts();
    @(negedge clk); hcs_n = 1'b0; haddr = 2'd1;
    @(negedge clk); hwr_n = 1'b0; hrd_n = 1'b0;
    repeat (8) @(negedge clk);
    hwr_n = 1'b1; hrd_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    hcs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    check("both_low_buserr", c_err, 1);
    check("both_low_loads", c_cfg + c_ctrl + c_wdog, 0);
    check("both_low_rdce", c_rdce, 0);
    check("both_low_hdataout", int'(hdataout), 8'h3C);
    clear_counts();
    do_write(2'd2, 8'h10, lat);
    check("after_err_wdogdivld", c_wdog, 1);
    check("after_err_wrtdata", int'(wrtdata), 8'h10);

    // Chip select dropped 3 clocks before the write strobe: aborted.
    clear_counts();
    @(negedge clk); hcs_n = 1'b0; haddr = 2'd1; hdatain = 8'h99;
    @(negedge clk); hwr_n = 1'b0;
    repeat (8) @(negedge clk);
    hcs_n = 1'b1;
    repeat (3) @(negedge clk);
    hwr_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    check("abort_loads", c_cfg + c_ctrl + c_wdog, 0);
    check("abort_buserr", c_err, 0);
    clear_counts();
    do_write(2'd1, 8'h42, lat);
    check("after_abort_ctrlld", c_ctrl, 1);
    check("after_abort_wrtdata", int'(wrtdata), 8'h42);
    check("after_abort_latency", lat, SYNC + 1);

    // Reset in WRACT with hwr_n held low across reset release.
    clear_counts();
    @(negedge clk); hcs_n = 1'b0; haddr = 2'd0; hdatain = 8'h66;
    @(negedge clk); hwr_n = 1'b0;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_outputs", out_word(), 0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    hwr_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    hcs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    check("midreset_loads", c_cfg + c_ctrl + c_wdog, 0);
    check("midreset_buserr", c_err, 0);
    clear_counts();
    do_write(2'd0, 8'h05, lat);
    check("after_reset_cfgld", c_cfg, 1);
    check("after_reset_wrtdata", int'(wrtdata), 8'h05);

    check("loads_onehot", c_multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
